dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the single-ported data memory in the MIPS pipeline. It shares the memory between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port).
- The CPU has fixed priority.
- A starvation counter guarantees the DBG port forward progress.
- Each accepted request is registered into a one-deep issue stage that drives the memory's Address/Write_Data/MemRead/MemWrite.
- Read data is captured and returned with a valid pulse.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of both request ports
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive lost DBG arbitration cycles before DBG is forced to win (1..15)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- cpu_req  in  1  CPU access request, held until accepted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  cpu_req high and not accepted this cycle (combinational)
- cpu_rdata  out  DATA_W  CPU read data, valid when cpu_rvalid
- cpu_rvalid  out  1  one-cycle read-return pulse
- dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  DBG request, same semantics as the CPU port
- dbg_gnt  out  1  DBG request accepted this cycle (combinational)
- dbg_rdata  out  DATA_W  DBG read data
- dbg_rvalid  out  1  one-cycle read-return pulse
- err  out  1  one-cycle pulse: a misaligned access was accepted
- mem_addr  out  ADDR_W  word index to memory = issued addr[ADDR_W-1:2], zero-extended
- mem_wdata  out  DATA_W  issued write data
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data (combinational from memory)

## Operation
Arbitration, combinational each cycle:
- Only one requester high: that requester is accepted.
- Both high: CPU is accepted, unless starve_cnt == STARVE_LIMIT; then DBG is accepted.
- starve_cnt (4 bits):
  - increments when dbg_req is high and DBG is not accepted; saturates at STARVE_LIMIT;
  - clears when DBG is accepted or dbg_req is low.

Issue FSM. The state records the owner of the issue register.
- States: IDLE, ISS_CPU, ISS_DBG.
- Next state is ISS_CPU or ISS_DBG per the acceptance above; IDLE if nothing is accepted.
- On acceptance, the issue register loads we, addr and wdata from the winner.
- Accesses can be back-to-back with no bubbles. The state may go ISS_CPU→ISS_CPU or ISS_CPU→ISS_DBG directly.

Memory drive, registered from the issue register:
- IDLE: mem_read = 0, mem_write = 0.
- Issued read: mem_read = 1, mem_write = 0.
- Issued write: mem_read = 0, mem_write = 1.
- Never both strobes high.

Misalignment:
- An accepted request with addr[1:0] != 0 is issued with both strobes 0.
- err pulses in the issue cycle.
- A misaligned read returns rdata = 0 with a normal rvalid pulse.

Read return:
- In an issue cycle that is a read, mem_rdata (0 if misaligned) is captured at the rising edge ending that cycle.
- The capture goes to cpu_rdata or dbg_rdata by owner, with the matching rvalid high for exactly the next cycle.
- The other port's rdata holds its last value.
- Writes produce no rvalid.

## Timing
- Request seen in cycle N with acceptance → issue (mem strobes) in N+1 → rvalid and rdata in N+2.
- Sustained throughput is 1 access per cycle.
- CPU port: cpu_stall is high in every cycle cpu_req is high and DBG wins. The CPU holds its request; the request is accepted in the first cycle cpu_stall is low.
- DBG port: dbg_gnt may be high at most one cycle per request. DBG drops dbg_req or presents a new request the cycle after dbg_gnt.
- Simultaneous events:
  - A new acceptance in N+1 and a return for N in N+2 coexist.
  - A CPU return and a DBG issue can occur in the same cycle.
- Reset low, at any time:
  - FSM → IDLE; starve_cnt, issue register, rdata and all outputs → 0.
  - In-flight accesses are dropped: no strobe and no rvalid after reset rises.
  - The first acceptance is possible in the first cycle after reset deasserts.
- Reset values: cpu_stall follows cpu_req; dbg_gnt = 0; cpu_rdata = dbg_rdata = 0; cpu_rvalid = dbg_rvalid = err = 0; mem_addr = mem_wdata = 0; mem_read = mem_write = 0.

## Test plan
- CPU read only: cpu_req, addr 0x24, mem[9] = 0x00007A10 → mem_addr = 9 and mem_read in N+1; cpu_rvalid with cpu_rdata = 0x00007A10 in N+2; cpu_stall never set.
- Back-to-back CPU write then read: write 0xDEADBEEF to 0x20, then read 0x20 on the next cycle → mem_write then mem_read on consecutive cycles at mem_addr = 8; cpu_rdata = 0xDEADBEEF.
- Contention: both requesting continuously, STARVE_LIMIT = 4 → CPU wins 4 cycles; dbg_gnt and cpu_stall are high on the 5th; the pattern repeats 4:1.
- Misaligned DBG read at 0x22 → no mem strobes; err pulses in the issue cycle; dbg_rvalid with dbg_rdata = 0.
- Reset asserted in the cycle a CPU read is issued → no cpu_rvalid afterward; all outputs are 0 during reset; starve_cnt restarts from 0.
- DBG alone while CPU is idle → dbg_gnt in the same cycle; no starvation counting.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the pipeline
// MEM stage (CPU port) and a debug/loader port (DBG port).
//   - CPU has fixed priority; a starvation counter forces a DBG win after
//     STARVE_LIMIT consecutive lost DBG arbitration cycles.
//   - Winner is registered into a one-deep issue stage that drives the memory.
//   - Read data is captured at the end of the issue cycle and returned to the
//     owning port with a one-cycle rvalid pulse.
// Ports:
//   clk, reset (async, active-low)
//   cpu_req/we/addr/wdata -> cpu_stall (comb), cpu_rdata, cpu_rvalid
//   dbg_req/we/addr/wdata -> dbg_gnt (comb), dbg_rdata, dbg_rvalid
//   err        : misaligned access issued this cycle
//   mem_addr/mem_wdata/mem_read/mem_write -> memory, mem_rdata <- memory
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned       CNT_W = 4;
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISS_CPU = 2'd1,
    ISS_DBG = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    starve_q, starve_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                dbg_rvalid_q, dbg_rvalid_d;

  logic                force_dbg;
  logic                cpu_win;
  logic                dbg_win;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;
  logic                win_mis;
  logic                rd_issued;
  logic [DATA_W-1:0]   rdata_cap;

  // Arbitration, next-state and issue/return logic
  always_comb begin
    state_d      = IDLE;
    starve_d     = '0;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    err_d        = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_rvalid_d = 1'b0;
    dbg_rdata_d  = dbg_rdata_q;
    dbg_rvalid_d = 1'b0;
    win_we       = 1'b0;
    win_addr     = '0;
    win_wdata    = '0;

    force_dbg = (starve_q == LIMIT);
    dbg_win   = dbg_req & (~cpu_req | force_dbg);
    cpu_win   = cpu_req & ~dbg_win;

    // Handshakes are masked while reset is low so nothing looks accepted
    cpu_stall = cpu_req & ~(cpu_win & reset);
    dbg_gnt   = dbg_win & reset;

    // Count consecutive lost DBG cycles, saturating at the limit
    if (dbg_req && !dbg_win) begin
      starve_d = force_dbg ? starve_q : starve_q + CNT_W'(1);
    end

    if (dbg_win) begin
      win_we    = dbg_we;
      win_addr  = dbg_addr;
      win_wdata = dbg_wdata;
      state_d   = ISS_DBG;
    end else if (cpu_win) begin
      win_we    = cpu_we;
      win_addr  = cpu_addr;
      win_wdata = cpu_wdata;
      state_d   = ISS_CPU;
    end
    win_mis = (win_addr[1:0] != 2'b00);

    // Load the issue stage from the winner; misaligned accesses get no strobe
    if (cpu_win || dbg_win) begin
      we_d        = win_we;
      mem_addr_d  = {2'b00, win_addr[ADDR_W-1:2]};
      mem_wdata_d = win_wdata;
      mem_read_d  = ~win_we & ~win_mis;
      mem_write_d = win_we & ~win_mis;
      err_d       = win_mis;
    end

    // Capture read data at the end of a read issue cycle (zero if misaligned)
    rd_issued = (state_q != IDLE) & ~we_q;
    rdata_cap = err_q ? '0 : mem_rdata;
    if (rd_issued && state_q == ISS_CPU) begin
      cpu_rvalid_d = 1'b1;
      cpu_rdata_d  = rdata_cap;
    end
    if (rd_issued && state_q == ISS_DBG) begin
      dbg_rvalid_d = 1'b1;
      dbg_rdata_d  = rdata_cap;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      err_q        <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
      dbg_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      err_q        <= err_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign err        = err_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_rvalid = dbg_rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a reference model predicts acceptances,
// memory issues and read returns; a monitor matches them against DUT outputs.
module tb_dmem_arbiter;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int          LIM = 4;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata;
  logic          cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, err;
  logic [DW-1:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_read, mem_write;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          cyc;
    logic        rd;
    logic        wr;
    logic        er;
    logic [31:0] word;
    logic [31:0] wdata;
  } iss_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } ret_t;

  iss_t        iss_q[$];
  ret_t        cret_q[$];
  ret_t        dret_q[$];
  int          n_checks;
  int          n_pass;
  int          cyc;
  int          ref_starve;
  logic        last_cpu_acc;
  logic        last_dbg_acc;
  bit          count_gnt;
  int          gnt_cnt;
  logic [31:0] exp_cpu_rdata;
  logic [31:0] exp_dbg_rdata;
  logic [31:0] ref_mem[64];
  logic [31:0] tb_mem[64];

  // Simple combinational-read memory
  assign mem_rdata = tb_mem[mem_addr[5:0]];
  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_addr[5:0]] = mem_wdata;
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name, input int exp_cyc);
    n_checks++;
    $display("FAIL %s: got nothing/unexpected, expected event at cycle %0d (now %0d)",
             name, exp_cyc, cyc);
  endtask

  // Reference model: decides the winner from the arbitration rules and
  // predicts the memory issue and read return for each acceptance.
  always @(negedge clk) begin
    logic        dwin, cwin, we, mis;
    logic [31:0] addr, wdata, word;
    iss_t        ie;
    ret_t        re;
    if (!reset) begin
      iss_q.delete();
      cret_q.delete();
      dret_q.delete();
      ref_starve   = 0;
      last_cpu_acc = 1'b0;
      last_dbg_acc = 1'b0;
      chk("stall_in_reset", 64'(cpu_stall), 64'(cpu_req));
      chk("gnt_in_reset", 64'(dbg_gnt), 64'(1'b0));
    end else begin
      dwin = dbg_req && (!cpu_req || ref_starve == LIM);
      cwin = cpu_req && !dwin;
      chk("cpu_stall", 64'(cpu_stall), 64'(cpu_req && !cwin));
      chk("dbg_gnt", 64'(dbg_gnt), 64'(dwin));
      if (count_gnt && dbg_gnt) gnt_cnt++;
      if (dbg_req && !dwin) ref_starve = (ref_starve + 1 > LIM) ? LIM : ref_starve + 1;
      else ref_starve = 0;
      last_cpu_acc = cwin;
      last_dbg_acc = dwin;
      if (cwin || dwin) begin
        we    = dwin ? dbg_we : cpu_we;
        addr  = dwin ? dbg_addr : cpu_addr;
        wdata = dwin ? dbg_wdata : cpu_wdata;
        mis   = (addr % 4) != 0;
        word  = addr / 4;
        ie.cyc = cyc + 1; ie.rd = !we && !mis; ie.wr = we && !mis; ie.er = mis;
        ie.word = word; ie.wdata = wdata;
        iss_q.push_back(ie);
        if (we && !mis) ref_mem[word[5:0]] = wdata;
        if (!we) begin
          re.cyc  = cyc + 2;
          re.data = mis ? 32'h0 : ref_mem[word[5:0]];
          if (dwin) dret_q.push_back(re);
          else cret_q.push_back(re);
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard queues.
  always @(negedge clk) begin
    iss_t e;
    ret_t r;
    if (!reset) begin
      exp_cpu_rdata = 32'h0;
      exp_dbg_rdata = 32'h0;
      chk("rst_rdata", {cpu_rdata, dbg_rdata}, 64'h0);
      chk("rst_mem", {mem_addr, mem_wdata}, 64'h0);
      chk("rst_flags", 64'({cpu_rvalid, dbg_rvalid, err, mem_read, mem_write}), 64'h0);
    end else begin
      while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
        fail_now("issue_missing", iss_q[0].cyc);
        void'(iss_q.pop_front());
      end
      while (cret_q.size() > 0 && cret_q[0].cyc < cyc) begin
        fail_now("cpu_rvalid_missing", cret_q[0].cyc);
        void'(cret_q.pop_front());
      end
      while (dret_q.size() > 0 && dret_q[0].cyc < cyc) begin
        fail_now("dbg_rvalid_missing", dret_q[0].cyc);
        void'(dret_q.pop_front());
      end
      if (mem_read || mem_write || err) begin
        if (iss_q.size() == 0) fail_now("issue_spurious", cyc);
        else begin
          e = iss_q.pop_front();
          chk("issue_cycle", 64'(cyc), 64'(e.cyc));
          chk("issue_rd_wr_err", 64'({mem_read, mem_write, err}), 64'({e.rd, e.wr, e.er}));
          chk("mem_addr", 64'(mem_addr), 64'(e.word));
          if (e.wr) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
        end
      end
      if (cpu_rvalid) begin
        if (cret_q.size() == 0) fail_now("cpu_rvalid_spurious", cyc);
        else begin
          r = cret_q.pop_front();
          chk("cpu_ret_cycle", 64'(cyc), 64'(r.cyc));
          exp_cpu_rdata = r.data;
        end
      end
      if (dbg_rvalid) begin
        if (dret_q.size() == 0) fail_now("dbg_rvalid_spurious", cyc);
        else begin
          r = dret_q.pop_front();
          chk("dbg_ret_cycle", 64'(cyc), 64'(r.cyc));
          exp_dbg_rdata = r.data;
        end
      end
      chk("cpu_rdata", 64'(cpu_rdata), 64'(exp_cpu_rdata));
      chk("dbg_rdata", 64'(dbg_rdata), 64'(exp_dbg_rdata));
    end
  end

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 255));
    if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    clk = 1'b0; reset = 1'b0; cyc = 0;
    n_checks = 0; n_pass = 0; gnt_cnt = 0; count_gnt = 1'b0;
    ref_starve = 0; last_cpu_acc = 1'b0; last_dbg_acc = 1'b0;
    exp_cpu_rdata = 32'h0; exp_dbg_rdata = 32'h0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h4; dbg_wdata = 0;
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[9]  = 32'h0000_7A10;
    ref_mem[9] = 32'h0000_7A10;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1; dbg_req = 0; cpu_req = 1; cpu_addr = 32'h24;

    // CPU read of 0x24 (request already applied at reset release)
    idle(4);
    // Back-to-back CPU write then read of 0x20
    drive(1, 1, 32'h20, 32'hDEAD_BEEF, 0, 0, 32'h0, 32'h0);
    drive(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0);
    idle(4);
    // Sustained contention: DBG should win every 5th cycle
    count_gnt = 1'b1;
    repeat (15) drive(1, 0, 32'h40, 32'h0, 1, 0, 32'h44, 32'h0);
    @(posedge clk);
    count_gnt = 1'b0;
    chk("contention_dbg_wins", 64'(gnt_cnt), 64'd3);
    idle(4);
    // Misaligned DBG read
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h22, 32'h0);
    idle(4);
    // Build up starvation, then reset during a CPU read issue cycle
    repeat (3) drive(1, 0, 32'h30, 32'h0, 1, 0, 32'h34, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (6) drive(1, 0, 32'h30, 32'h0, 1, 0, 32'h34, 32'h0);
    idle(4);
    // DBG alone
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h50, 32'h1234_5678);
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h50, 32'h0);
    idle(4);

    // Randomized traffic honouring the hold-until-accepted protocol
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (!(cpu_req && !last_cpu_acc)) begin
        cpu_req   = ($urandom_range(0, 99) < 60);
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = rand_addr();
        cpu_wdata = $urandom;
      end
      if (!(dbg_req && !last_dbg_acc)) begin
        dbg_req   = ($urandom_range(0, 99) < 45);
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = rand_addr();
        dbg_wdata = $urandom;
      end
    end
    idle(6);
    @(negedge clk);
    chk("iss_q_drained", 64'(iss_q.size()), 64'd0);
    chk("cret_q_drained", 64'(cret_q.size()), 64'd0);
    chk("dret_q_drained", 64'(dret_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
